// File: rtl/instruction_decode.sv
// RV32I decode stage: register file with write-through bypass, immediate/control
// decode, load-use hazard detection and the ID/EX pipeline register.
module instruction_decode #(
    parameter int unsigned BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] PC_in,
    input  logic [BW-1:0] Instruction_in,
    input  logic          flush,
    input  logic          WB_we,
    input  logic [4:0]    WB_rd,
    input  logic [BW-1:0] WB_data,
    output logic          stall_out,
    output logic          ID_valid,
    output logic [BW-1:0] ID_PC,
    output logic [BW-1:0] ID_rs1_data,
    output logic [BW-1:0] ID_rs2_data,
    output logic [BW-1:0] ID_imm,
    output logic [4:0]    ID_rs1,
    output logic [4:0]    ID_rs2,
    output logic [4:0]    ID_rd,
    output logic [2:0]    ID_funct3,
    output logic [6:0]    ID_funct7,
    output logic [6:0]    ID_opcode,
    output logic          ID_regwrite,
    output logic          ID_memread,
    output logic          ID_memwrite,
    output logic          ID_alusrc,
    output logic          ID_branch,
    output logic          ID_jump,
    output logic          ID_illegal
);

    localparam int unsigned NREG = 32;
    localparam int unsigned IW   = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [BW-1:0] regs [NREG];

    logic [IW-1:0] instr;
    logic [6:0]    dec_opcode;
    logic [4:0]    dec_rd;
    logic [2:0]    dec_funct3;
    logic [6:0]    dec_funct7;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [IW-1:0] imm32;
    logic [BW-1:0] dec_imm;
    logic [BW-1:0] rs1_data;
    logic [BW-1:0] rs2_data;
    logic          dec_regwrite;
    logic          dec_memread;
    logic          dec_memwrite;
    logic          dec_alusrc;
    logic          dec_branch;
    logic          dec_jump;
    logic          dec_illegal;

    // Field extraction, immediate formation and control decode
    always_comb begin
        instr        = Instruction_in[IW-1:0];
        dec_opcode   = instr[6:0];
        dec_rd       = instr[11:7];
        dec_funct3   = instr[14:12];
        dec_rs1      = instr[19:15];
        dec_rs2      = instr[24:20];
        dec_funct7   = instr[31:25];
        imm32        = '0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_illegal  = 1'b0;
        case (dec_opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
            end
            OP_IALU, OP_LOAD, OP_JALR: begin
                imm32        = {{20{instr[31]}}, instr[31:20]};
                dec_rs2      = '0;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_memread  = (dec_opcode == OP_LOAD);
                dec_jump     = (dec_opcode == OP_JALR);
            end
            OP_STORE: begin
                imm32        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_memwrite = 1'b1;
                dec_alusrc   = 1'b1;
            end
            OP_BRANCH: begin
                imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_branch = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm32        = {instr[31:12], 12'b0};
                dec_rs1      = '0;
                dec_rs2      = '0;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
            end
            OP_JAL: begin
                imm32        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_rs1      = '0;
                dec_rs2      = '0;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_jump     = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_rd == '0) begin
            dec_regwrite = 1'b0;
        end
        dec_imm = BW'($signed(imm32));
    end

    // Register reads; a same-cycle writeback to the read index wins over the array
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (dec_rs1 != '0) begin
            rs1_data = (WB_we && (WB_rd == dec_rs1)) ? WB_data : regs[dec_rs1];
        end
        if (dec_rs2 != '0) begin
            rs2_data = (WB_we && (WB_rd == dec_rs2)) ? WB_data : regs[dec_rs2];
        end
    end

    // Load in ID/EX whose destination is needed by the instruction now in decode
    assign stall_out = ID_valid && ID_memread && (ID_rd != '0) &&
                       ((ID_rd == dec_rs1) || (ID_rd == dec_rs2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (WB_we && (WB_rd != '0)) begin
            regs[WB_rd] <= WB_data;
        end
    end

    // ID/EX register; reset, flush and stall all insert a bubble
    always_ff @(posedge clk) begin
        if (!rst || flush || stall_out) begin
            ID_valid    <= 1'b0;
            ID_PC       <= '0;
            ID_rs1_data <= '0;
            ID_rs2_data <= '0;
            ID_imm      <= '0;
            ID_rs1      <= '0;
            ID_rs2      <= '0;
            ID_rd       <= '0;
            ID_funct3   <= '0;
            ID_funct7   <= '0;
            ID_opcode   <= '0;
            ID_regwrite <= 1'b0;
            ID_memread  <= 1'b0;
            ID_memwrite <= 1'b0;
            ID_alusrc   <= 1'b0;
            ID_branch   <= 1'b0;
            ID_jump     <= 1'b0;
            ID_illegal  <= 1'b0;
        end else begin
            ID_valid    <= 1'b1;
            ID_PC       <= PC_in;
            ID_rs1_data <= rs1_data;
            ID_rs2_data <= rs2_data;
            ID_imm      <= dec_imm;
            ID_rs1      <= dec_rs1;
            ID_rs2      <= dec_rs2;
            ID_rd       <= dec_rd;
            ID_funct3   <= dec_funct3;
            ID_funct7   <= dec_funct7;
            ID_opcode   <= dec_opcode;
            ID_regwrite <= dec_regwrite;
            ID_memread  <= dec_memread;
            ID_memwrite <= dec_memwrite;
            ID_alusrc   <= dec_alusrc;
            ID_branch   <= dec_branch;
            ID_jump     <= dec_jump;
            ID_illegal  <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

    localparam int unsigned BW = 32;

    logic          clk;
    logic          rst;
    logic [BW-1:0] PC_in;
    logic [BW-1:0] Instruction_in;
    logic          flush;
    logic          WB_we;
    logic [4:0]    WB_rd;
    logic [BW-1:0] WB_data;
    logic          stall_out;
    logic          ID_valid;
    logic [BW-1:0] ID_PC;
    logic [BW-1:0] ID_rs1_data;
    logic [BW-1:0] ID_rs2_data;
    logic [BW-1:0] ID_imm;
    logic [4:0]    ID_rs1;
    logic [4:0]    ID_rs2;
    logic [4:0]    ID_rd;
    logic [2:0]    ID_funct3;
    logic [6:0]    ID_funct7;
    logic [6:0]    ID_opcode;
    logic          ID_regwrite;
    logic          ID_memread;
    logic          ID_memwrite;
    logic          ID_alusrc;
    logic          ID_branch;
    logic          ID_jump;
    logic          ID_illegal;

    int errors = 0;
    int checks = 0;

    // {regwrite, memread, memwrite, alusrc, branch, jump, illegal}
    logic [6:0] ctrl;
    assign ctrl = {ID_regwrite, ID_memread, ID_memwrite, ID_alusrc, ID_branch, ID_jump, ID_illegal};

    localparam logic [31:0] I_ADDI_X1  = 32'hFFB00093; // addi x1,x0,-5
    localparam logic [31:0] I_ADD_433  = 32'h00318233; // add x4,x3,x3
    localparam logic [31:0] I_ADD_455  = 32'h00528233; // add x4,x5,x5
    localparam logic [31:0] I_LW_X2    = 32'h0000A103; // lw x2,0(x1)
    localparam logic [31:0] I_ADD_526  = 32'h006102B3; // add x5,x2,x6
    localparam logic [31:0] I_SW       = 32'h0020A623; // sw x2,12(x1)
    localparam logic [31:0] I_BEQ      = 32'hFE000EE3; // beq x0,x0,-4
    localparam logic [31:0] I_JAL      = 32'h008000EF; // jal x1,+8
    localparam logic [31:0] I_LUI      = 32'h123453B7; // lui x7,0x12345
    localparam logic [31:0] I_NOP_X0   = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_ILLEGAL  = 32'h0000007F;

    instruction_decode #(.BW(BW)) dut (
        .clk(clk), .rst(rst), .PC_in(PC_in), .Instruction_in(Instruction_in),
        .flush(flush), .WB_we(WB_we), .WB_rd(WB_rd), .WB_data(WB_data),
        .stall_out(stall_out), .ID_valid(ID_valid), .ID_PC(ID_PC),
        .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_funct3(ID_funct3), .ID_funct7(ID_funct7), .ID_opcode(ID_opcode),
        .ID_regwrite(ID_regwrite), .ID_memread(ID_memread), .ID_memwrite(ID_memwrite),
        .ID_alusrc(ID_alusrc), .ID_branch(ID_branch), .ID_jump(ID_jump),
        .ID_illegal(ID_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        Instruction_in = ins;
        PC_in          = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        drive(I_LW_X2, 32'h100);
        WB_we = 1'b1; WB_rd = 5'd5; WB_data = 32'hA5A5A5A5;
        step();
        step();
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ID_valid); end
        checks++; if (ctrl !== 7'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000000", ctrl); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
        checks++; if (ID_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", ID_PC); end
        rst = 1'b1; WB_we = 1'b0;
        drive(I_ADD_455, 32'h4);
        step();
        checks++; if (ID_rs1_data !== 32'h0) begin errors++; $display("FAIL reset_x5_read got=%h exp=0", ID_rs1_data); end
        checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL reset_exit_valid got=%b exp=1", ID_valid); end
    endtask

    task automatic test_addi();
        drive(I_ADDI_X1, 32'h10);
        step();
        checks++; if (ID_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", ID_rd); end
        checks++; if (ID_imm !== 32'hFFFFFFFB) begin errors++; $display("FAIL addi_imm got=%h exp=fffffffb", ID_imm); end
        checks++; if (ctrl !== 7'b1001000) begin errors++; $display("FAIL addi_ctrl got=%b exp=1001000", ctrl); end
        checks++; if (ID_PC !== 32'h10) begin errors++; $display("FAIL addi_pc got=%h exp=10", ID_PC); end
        checks++; if (ID_rs2 !== 5'd0) begin errors++; $display("FAIL addi_rs2 got=%0d exp=0", ID_rs2); end
        checks++; if (ID_opcode !== 7'h13) begin errors++; $display("FAIL addi_opcode got=%h exp=13", ID_opcode); end
    endtask

    task automatic test_bypass();
        drive(I_ADD_433, 32'h14);
        WB_we = 1'b1; WB_rd = 5'd0; WB_data = 32'hDEADBEEF;
        step();
        checks++; if ({ID_rs1_data, ID_rs2_data} !== 64'h0) begin errors++; $display("FAIL bypass_x0 got=%h_%h exp=0_0", ID_rs1_data, ID_rs2_data); end
        WB_rd = 5'd3;
        step();
        checks++; if (ID_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", ID_rs1_data); end
        checks++; if (ID_rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs2 got=%h exp=deadbeef", ID_rs2_data); end
        checks++; if (ctrl !== 7'b1000000 || ID_rd !== 5'd4) begin errors++; $display("FAIL add_decode got=%b/%0d exp=1000000/4", ctrl, ID_rd); end
        WB_we = 1'b0; WB_data = 32'h0;
        step();
        checks++; if (ID_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL regfile_x3 got=%h exp=deadbeef", ID_rs1_data); end
    endtask

    task automatic test_load_use();
        drive(I_LW_X2, 32'h20);
        step();
        checks++; if (ctrl !== 7'b1101000) begin errors++; $display("FAIL lw_ctrl got=%b exp=1101000", ctrl); end
        drive(I_ADD_526, 32'h24);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall_out); end
        WB_we = 1'b1; WB_rd = 5'd2; WB_data = 32'h12345678;
        step();
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", ID_valid); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got=%b exp=0", stall_out); end
        step();
        WB_we = 1'b0;
        checks++; if (ID_valid !== 1'b1 || ID_rd !== 5'd5 || ID_PC !== 32'h24) begin
            errors++; $display("FAIL lu_add got=v%b rd%0d pc%h exp=v1 rd5 pc24", ID_valid, ID_rd, ID_PC);
        end
        checks++; if (ID_rs1_data !== 32'h12345678) begin errors++; $display("FAIL lu_rs1_bypass got=%h exp=12345678", ID_rs1_data); end
        checks++; if (ID_rs2 !== 5'd6 || ID_rs2_data !== 32'h0) begin errors++; $display("FAIL lu_rs2 got=%0d/%h exp=6/0", ID_rs2, ID_rs2_data); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_no_restall got=%b exp=0", stall_out); end
    endtask

    task automatic test_flush();
        drive(I_ADDI_X1, 32'h30);
        flush = 1'b1;
        step();
        checks++; if (ID_valid !== 1'b0 || ctrl !== 7'b0) begin errors++; $display("FAIL flush_bubble got=v%b c%b exp=v0 c0", ID_valid, ctrl); end
        flush = 1'b0;
        drive(I_LW_X2, 32'h34);
        step();
        drive(I_ADD_526, 32'h38);
        flush = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL flush_stall_comb got=%b exp=1", stall_out); end
        step();
        flush = 1'b0;
        checks++; if (ID_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall_bubble got=v%b s%b exp=v0 s0", ID_valid, stall_out); end
        drive(I_ADDI_X1, 32'h80);
        step();
        checks++; if (ID_valid !== 1'b1 || ID_PC !== 32'h80) begin errors++; $display("FAIL flush_redirect got=v%b pc%h exp=v1 pc80", ID_valid, ID_PC); end
    endtask

    task automatic test_immediates();
        drive(I_BEQ, 32'h40);
        step();
        checks++; if (ID_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got=%h exp=fffffffc", ID_imm); end
        checks++; if (ctrl !== 7'b0000100) begin errors++; $display("FAIL beq_ctrl got=%b exp=0000100", ctrl); end
        drive(I_JAL, 32'h44);
        step();
        checks++; if (ID_imm !== 32'h8) begin errors++; $display("FAIL jal_imm got=%h exp=8", ID_imm); end
        checks++; if (ctrl !== 7'b1001010) begin errors++; $display("FAIL jal_ctrl got=%b exp=1001010", ctrl); end
        checks++; if (ID_rs1 !== 5'd0 || ID_rs2 !== 5'd0) begin errors++; $display("FAIL jal_rs got=%0d/%0d exp=0/0", ID_rs1, ID_rs2); end
        drive(I_SW, 32'h48);
        step();
        checks++; if (ID_imm !== 32'hC || ctrl !== 7'b0011000) begin errors++; $display("FAIL sw got=%h/%b exp=c/0011000", ID_imm, ctrl); end
        drive(I_LUI, 32'h4C);
        step();
        checks++; if (ID_imm !== 32'h12345000 || ID_rs1 !== 5'd0) begin errors++; $display("FAIL lui got=%h/%0d exp=12345000/0", ID_imm, ID_rs1); end
        drive(I_NOP_X0, 32'h50);
        step();
        checks++; if (ID_valid !== 1'b1 || ctrl !== 7'b0001000) begin errors++; $display("FAIL rd0_regwrite got=v%b c%b exp=v1 c0001000", ID_valid, ctrl); end
        drive(I_ILLEGAL, 32'h54);
        step();
        checks++; if (ID_valid !== 1'b1 || ctrl !== 7'b0000001) begin errors++; $display("FAIL illegal got=v%b c%b exp=v1 c0000001", ID_valid, ctrl); end
        checks++; if (ID_imm !== 32'h0) begin errors++; $display("FAIL illegal_imm got=%h exp=0", ID_imm); end
    endtask

    task automatic test_back_to_back();
        drive(I_ADDI_X1, 32'h60);
        step();
        drive(I_JAL, 32'h64);
        step();
        checks++; if (ID_PC !== 32'h64 || ID_jump !== 1'b1) begin errors++; $display("FAIL b2b_jal got=%h/%b exp=64/1", ID_PC, ID_jump); end
        drive(I_ADD_433, 32'h68);
        step();
        checks++; if (ID_PC !== 32'h68 || ID_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_add got=%h/%h exp=68/deadbeef", ID_PC, ID_rs1_data); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        WB_we = 1'b0; WB_rd = '0; WB_data = '0;
        PC_in = '0; Instruction_in = '0;
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_flush();
        test_immediates();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
